// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared LEGv8 multicycle datapath. It walks each
// instruction through fetch/decode/execute/memory/write-back, drives all
// datapath enables and mux selects, and absorbs memory wait states through a
// req/ack handshake.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg2loc,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        illegal,
  output logic        retire,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    LDWB    = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    ILLEGAL = 4'd9
  } state_t;

  state_t cur, nxt;

  // Cleared asynchronously by reset and set on the first edge after release.
  // All outputs are gated by it, so outputs (mem_req included) drop the moment
  // reset asserts and the first request appears one cycle after release.
  logic active;

  logic is_ldur, is_stur, is_cbz, is_rtype;

  assign is_ldur  = (opcode == 11'b11111000010);
  assign is_stur  = (opcode == 11'b11111000000);
  assign is_cbz   = (opcode[10:3] == 8'b10110100);
  assign is_rtype = (opcode == 11'b10001011000) ||  // ADD
                    (opcode == 11'b11001011000) ||  // SUB
                    (opcode == 11'b10001010000) ||  // AND
                    (opcode == 11'b10101010000);    // ORR

  assign state = cur;

  // State register and run flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur    <= FETCH;
      active <= 1'b0;
    end else begin
      cur    <= nxt;
      active <= 1'b1;
    end
  end

  // Next-state and output decode; Moore except the ack-gated enables,
  // reg2loc and the branch pc_src.
  always_comb begin
    nxt        = cur;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg2loc    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    retire     = 1'b0;

    if (!active) begin
      nxt = FETCH;
    end else begin
      case (cur)
        FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ack;
          if (mem_ack) nxt = DECODE;
        end
        DECODE: begin
          alu_src_b = 2'b10;
          reg2loc   = is_stur | is_cbz;
          if (is_ldur || is_stur) nxt = MEMADR;
          else if (is_rtype)      nxt = EXEC;
          else if (is_cbz)        nxt = BRANCH;
          else                    nxt = ILLEGAL;
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          reg2loc   = is_stur;
          if (is_ldur)      nxt = MEMRD;
          else if (is_stur) nxt = MEMWR;
          else              nxt = ILLEGAL;
        end
        MEMRD: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mdr_write = mem_ack;
          if (mem_ack) nxt = LDWB;
        end
        LDWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          pc_write   = 1'b1;
          retire     = 1'b1;
          nxt        = FETCH;
        end
        MEMWR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          iord     = 1'b1;
          reg2loc  = 1'b1;
          pc_write = mem_ack;
          retire   = mem_ack;
          if (mem_ack) nxt = FETCH;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          nxt       = RWB;
        end
        RWB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          retire    = 1'b1;
          nxt       = FETCH;
        end
        BRANCH: begin
          reg2loc  = 1'b1;
          alu_op   = 2'b01;
          pc_write = 1'b1;
          pc_src   = zero;
          retire   = 1'b1;
          nxt      = FETCH;
        end
        ILLEGAL: begin
          illegal = 1'b1;
          nxt     = ILLEGAL;
        end
        default: nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle pushes the
// hand-derived output vector for that cycle; a monitor on the falling edge
// pops and compares it against the DUT.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ack;
  logic        mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src;
  logic        reg_write, mem_to_reg, reg2loc, alu_src_a, illegal, retire;
  logic [1:0]  alu_src_b, alu_op;
  logic [3:0]  state;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg2loc(reg2loc),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal(illegal), .retire(retire), .state(state)
  );

  // Vector layout: {state, req we iord irw mdrw, pcw pcsrc, rw m2r r2l, a b op, ill ret}
  localparam logic [20:0] E_ZERO = {4'd0, 5'b00000, 2'b00, 3'b000, 5'b0_00_00, 2'b00};
  localparam logic [20:0] E_FW   = {4'd0, 5'b10000, 2'b00, 3'b000, 5'b0_00_00, 2'b00};
  localparam logic [20:0] E_FA   = {4'd0, 5'b10010, 2'b00, 3'b000, 5'b0_00_00, 2'b00};
  localparam logic [20:0] E_DR   = {4'd1, 5'b00000, 2'b00, 3'b000, 5'b0_10_00, 2'b00};
  localparam logic [20:0] E_DS   = {4'd1, 5'b00000, 2'b00, 3'b001, 5'b0_10_00, 2'b00};
  localparam logic [20:0] E_EX   = {4'd6, 5'b00000, 2'b00, 3'b000, 5'b1_00_10, 2'b00};
  localparam logic [20:0] E_RWB  = {4'd7, 5'b00000, 2'b10, 3'b100, 5'b0_00_00, 2'b01};
  localparam logic [20:0] E_MAL  = {4'd2, 5'b00000, 2'b00, 3'b000, 5'b1_10_00, 2'b00};
  localparam logic [20:0] E_MAS  = {4'd2, 5'b00000, 2'b00, 3'b001, 5'b1_10_00, 2'b00};
  localparam logic [20:0] E_MRW  = {4'd3, 5'b10100, 2'b00, 3'b000, 5'b0_00_00, 2'b00};
  localparam logic [20:0] E_MRA  = {4'd3, 5'b10101, 2'b00, 3'b000, 5'b0_00_00, 2'b00};
  localparam logic [20:0] E_LWB  = {4'd4, 5'b00000, 2'b10, 3'b110, 5'b0_00_00, 2'b01};
  localparam logic [20:0] E_MWW  = {4'd5, 5'b11100, 2'b00, 3'b001, 5'b0_00_00, 2'b00};
  localparam logic [20:0] E_MWA  = {4'd5, 5'b11100, 2'b10, 3'b001, 5'b0_00_00, 2'b01};
  localparam logic [20:0] E_BR1  = {4'd8, 5'b00000, 2'b11, 3'b001, 5'b0_00_01, 2'b01};
  localparam logic [20:0] E_BR0  = {4'd8, 5'b00000, 2'b10, 3'b001, 5'b0_00_01, 2'b01};
  localparam logic [20:0] E_ILL  = {4'd9, 5'b00000, 2'b00, 3'b000, 5'b0_00_00, 2'b10};

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  typedef struct {
    string       name;
    logic [20:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic [20:0] act;
  assign act = {state, mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src,
                reg_write, mem_to_reg, reg2loc, alu_src_a, alu_src_b, alu_op,
                illegal, retire};

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got %b want %b (t=%0t)", e.name, act, e.v, $time);
      end
    end
  end

  // One stimulus cycle: drive inputs just after the edge, queue the expectation.
  task automatic cyc(input string name, input logic rst, input logic [10:0] op,
                     input logic z, input logic ack, input logic [20:0] ev);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = rst;
    opcode  = op;
    zero    = z;
    mem_ack = ack;
    e.name  = name;
    e.v     = ev;
    q.push_back(e);
  endtask

  initial begin
    reset   = 1'b0;
    opcode  = '0;
    zero    = 1'b0;
    mem_ack = 1'b1;

    // Reset held with ack high, then release; ack during release cycle must be ignored.
    for (int unsigned i = 0; i < 3; i++) cyc("reset_hold", 1'b0, OP_ADD, 1'b0, 1'b1, E_ZERO);
    cyc("release_idle", 1'b1, OP_ADD, 1'b0, 1'b1, E_ZERO);
    cyc("first_req",    1'b1, OP_ADD, 1'b0, 1'b0, E_FW);

    // ADD, ack tied high: 0,1,6,7.
    cyc("add_fetch",  1'b1, OP_ADD, 1'b0, 1'b1, E_FA);
    cyc("add_decode", 1'b1, OP_ADD, 1'b0, 1'b1, E_DR);
    cyc("add_exec",   1'b1, OP_ADD, 1'b0, 1'b1, E_EX);
    cyc("add_rwb",    1'b1, OP_ADD, 1'b0, 1'b1, E_RWB);

    // LDUR: 2 wait cycles in FETCH, 3 in MEMRD.
    cyc("ld_fetch_w1", 1'b1, OP_LDUR, 1'b0, 1'b0, E_FW);
    cyc("ld_fetch_w2", 1'b1, OP_LDUR, 1'b0, 1'b0, E_FW);
    cyc("ld_fetch_a",  1'b1, OP_LDUR, 1'b0, 1'b1, E_FA);
    cyc("ld_decode",   1'b1, OP_LDUR, 1'b0, 1'b0, E_DR);
    cyc("ld_memadr",   1'b1, OP_LDUR, 1'b0, 1'b0, E_MAL);
    cyc("ld_memrd_w1", 1'b1, OP_LDUR, 1'b0, 1'b0, E_MRW);
    cyc("ld_memrd_w2", 1'b1, OP_LDUR, 1'b0, 1'b0, E_MRW);
    cyc("ld_memrd_w3", 1'b1, OP_LDUR, 1'b0, 1'b0, E_MRW);
    cyc("ld_memrd_a",  1'b1, OP_LDUR, 1'b0, 1'b1, E_MRA);
    cyc("ld_ldwb",     1'b1, OP_LDUR, 1'b0, 1'b0, E_LWB);

    // CBZ taken then not taken.
    cyc("cbz1_fetch",  1'b1, OP_CBZ, 1'b1, 1'b1, E_FA);
    cyc("cbz1_decode", 1'b1, OP_CBZ, 1'b1, 1'b0, E_DS);
    cyc("cbz1_branch", 1'b1, OP_CBZ, 1'b1, 1'b0, E_BR1);
    cyc("cbz0_fetch",  1'b1, OP_CBZ, 1'b0, 1'b1, E_FA);
    cyc("cbz0_decode", 1'b1, OP_CBZ, 1'b0, 1'b0, E_DS);
    cyc("cbz0_branch", 1'b1, OP_CBZ, 1'b0, 1'b0, E_BR0);

    // STUR with immediate ack: 0,1,2,5.
    cyc("st_fetch",  1'b1, OP_STUR, 1'b0, 1'b1, E_FA);
    cyc("st_decode", 1'b1, OP_STUR, 1'b0, 1'b0, E_DS);
    cyc("st_memadr", 1'b1, OP_STUR, 1'b0, 1'b0, E_MAS);
    cyc("st_memwr",  1'b1, OP_STUR, 1'b0, 1'b1, E_MWA);

    // STUR interrupted by reset in the second MEMWR wait cycle.
    cyc("str_fetch",   1'b1, OP_STUR, 1'b0, 1'b1, E_FA);
    cyc("str_decode",  1'b1, OP_STUR, 1'b0, 1'b0, E_DS);
    cyc("str_memadr",  1'b1, OP_STUR, 1'b0, 1'b0, E_MAS);
    cyc("str_memwr_w1",1'b1, OP_STUR, 1'b0, 1'b0, E_MWW);
    cyc("str_reset",   1'b0, OP_STUR, 1'b0, 1'b0, E_ZERO);
    cyc("str_reset2",  1'b0, OP_STUR, 1'b0, 1'b1, E_ZERO);
    cyc("str_release", 1'b1, OP_BAD,  1'b0, 1'b0, E_ZERO);
    cyc("str_refetch", 1'b1, OP_BAD,  1'b0, 1'b0, E_FW);

    // Unsupported opcode: DECODE then terminal ILLEGAL, ack ignored.
    cyc("ill_fetch",  1'b1, OP_BAD, 1'b0, 1'b1, E_FA);
    cyc("ill_decode", 1'b1, OP_BAD, 1'b0, 1'b1, E_DR);
    for (int unsigned i = 0; i < 20; i++) cyc("ill_hold", 1'b1, OP_BAD, 1'b0, 1'b1, E_ILL);
    cyc("ill_reset",  1'b0, OP_BAD, 1'b0, 1'b1, E_ZERO);

    // Drain the scoreboard within a bounded number of cycles.
    for (int unsigned i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
